// File: rtl/note_judge_if.sv
// note_judge_if: chart push channel and judgement result channel of the timing-judgement stage.
interface note_judge_if;
  logic note_wr;
  logic [1:0] note_lane;
  logic [19:0] note_time;
  logic note_ready;
  logic judge_valid;
  logic [1:0] judge_grade;
  logic [1:0] judge_lane;
  modport master (output note_wr, note_lane, note_time, input note_ready, judge_valid, judge_grade, judge_lane);
  modport slave (input note_wr, note_lane, note_time, output note_ready, judge_valid, judge_grade, judge_lane);
endinterface

// File: rtl/note_judge.sv
// note_judge: song clock, per-lane note queues and press timing grades with score/combo tracking.
module note_judge #(
  parameter int PERFECT_WIN = 40,
  parameter int GREAT_WIN = 80,
  parameter int GOOD_WIN = 120,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  input logic tick_ms,
  input logic start,
  input logic [3:0] keys,
  note_judge_if.slave bus,
  output logic [19:0] song_ms,
  output logic [31:0] score,
  output logic [15:0] combo,
  output logic [15:0] max_combo,
  output logic overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic running;
  logic [3:0] keys_q, pend, press, full, empty, clr_mask;
  logic [19:0] mem [4][FIFO_DEPTH];
  logic [AW:0] wp [4];
  logic [AW:0] rp [4];
  logic [1:0] scan, grade;
  logic [20:0] h, t, d;
  logic ne, late, early, miss, hit, clr, push, dropped;
  logic [31:0] pts;
  logic [32:0] score_sum;
  logic [31:0] score_n;
  logic [15:0] combo_n, max_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb state_n = start ? RUN : state;
  always_comb running = state == RUN;
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      full[i] = (wp[i] - rp[i]) == (AW+1)'(FIFO_DEPTH);
      empty[i] = wp[i] == rp[i];
    end
  end
  assign bus.note_ready = !full[bus.note_lane];
  assign push = bus.note_wr & bus.note_ready;
  assign dropped = bus.note_wr & ~bus.note_ready;
  assign press = keys & ~keys_q;
  // Lane under service compares its queue head against the song clock with one bit of headroom.
  assign h = {1'b0, mem[scan][rp[scan][AW-1:0]]};
  assign t = {1'b0, song_ms};
  assign ne = ~empty[scan];
  assign late = ne & (t > h + 21'(GOOD_WIN));
  assign early = h > t + 21'(GOOD_WIN);
  assign miss = running & late;
  assign hit = running & ~late & pend[scan] & ne & ~early;
  assign clr = running & ~late & pend[scan];
  assign clr_mask = clr ? 4'(1) << scan : 4'd0;
  assign d = t >= h ? t - h : h - t;
  assign grade = miss ? 2'd3 : d <= 21'(PERFECT_WIN) ? 2'd0 : d <= 21'(GREAT_WIN) ? 2'd1 : 2'd2;
  assign pts = d <= 21'(PERFECT_WIN) ? 32'd300 : d <= 21'(GREAT_WIN) ? 32'd100 : 32'd50;
  assign score_sum = {1'b0, score} + {1'b0, pts};
  assign score_n = !hit ? score : score_sum[32] ? 32'hFFFF_FFFF : score_sum[31:0];
  assign combo_n = miss ? 16'd0 : !hit ? combo : &combo ? combo : combo + 16'd1;
  assign max_n = combo_n > max_combo ? combo_n : max_combo;
  always_ff @(posedge clk)
    if (push) mem[bus.note_lane][wp[bus.note_lane][AW-1:0]] <= bus.note_time;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      keys_q <= '0;
      scan <= '0;
      pend <= '0;
      song_ms <= '0;
      score <= '0;
      combo <= '0;
      max_combo <= '0;
      overflow <= 1'b0;
      bus.judge_valid <= 1'b0;
      bus.judge_grade <= '0;
      bus.judge_lane <= '0;
      for (int i = 0; i < 4; i++) begin
        wp[i] <= '0;
        rp[i] <= '0;
      end
    end else begin
      keys_q <= keys;
      scan <= scan + 2'd1;
      if (start) begin
        pend <= '0;
        song_ms <= '0;
        score <= '0;
        combo <= '0;
        max_combo <= '0;
        overflow <= 1'b0;
        bus.judge_valid <= 1'b0;
        for (int i = 0; i < 4; i++) begin
          wp[i] <= '0;
          rp[i] <= '0;
        end
      end else begin
        if (running & tick_ms & ~&song_ms) song_ms <= song_ms + 20'd1;
        overflow <= overflow | dropped;
        pend <= (pend & ~clr_mask) | (press & {4{running}});
        bus.judge_valid <= miss | hit;
        if (miss | hit) begin
          bus.judge_grade <= grade;
          bus.judge_lane <= scan;
        end
        score <= score_n;
        combo <= combo_n;
        max_combo <= max_n;
        for (int i = 0; i < 4; i++) begin
          if (push && bus.note_lane == 2'(i)) wp[i] <= wp[i] + 1'b1;
          if ((miss | hit) && scan == 2'(i)) rp[i] <= rp[i] + 1'b1;
        end
      end
    end
endmodule

// File: doc/note_judge.md
# note_judge

Timing-judgement stage for the 4-lane rhythm game, directly downstream of the keyboard decoder (lane key levels a/s/k/l) and the chart reader (note timestamps). It keeps a millisecond song clock and a per-lane note queue, turns key presses into PERFECT/GREAT/GOOD/MISS grades, and produces the `score` and `combo` values that drive the display and LEDs.

## Interface
- PERFECT_WIN, 40: half-window in ms for PERFECT
- GREAT_WIN, 80: half-window in ms for GREAT
- GOOD_WIN, 120: half-window in ms for GOOD; also the miss threshold
- FIFO_DEPTH, 4: notes queued per lane; power of two
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- tick_ms  in  1  one-cycle pulse every 1 ms
- start  in  1  one-cycle pulse: begin song
- keys  in  4  lane key levels, bit0=a, bit1=s, bit2=k, bit3=l; 1 = pressed
- note_wr  in  1  push note into the lane queue
- note_lane  in  2  lane of pushed note
- note_time  in  20  hit time of pushed note, ms from song start
- note_ready  out  1  combinational: queue of `note_lane` not full
- song_ms  out  20  song clock
- judge_valid  out  1  one-cycle pulse per judgement
- judge_grade  out  2  0=PERFECT, 1=GREAT, 2=GOOD, 3=MISS
- judge_lane  out  2  lane of judgement
- score  out  32  accumulated score
- combo  out  16  current combo
- max_combo  out  16  highest combo this song
- overflow  out  1  sticky: a push was dropped

## Operation
- Reset (rst=0): all outputs, queues, pointers, press flags and key history cleared to 0; running=0.
- `start`: clears song_ms, score, combo, max_combo, overflow, all queues and press flags; running=1. `start` overrides every other same-cycle event.
- Song clock: while running, song_ms +1 on each tick_ms; saturates at 0xFFFFF.
- Queues: a push is accepted when note_wr=1 and the queue is not full. A push to a full queue is dropped and sets overflow. Notes are pushed in time order per lane, and the block does not reorder them. A push and a pop on the same lane in the same cycle are both honoured.
- Press detect: press = keys & ~keys_q, where keys_q is registered. A press sets pend[lane]. A new press on an already-pending lane is absorbed.
- Scanner: a 2-bit counter cycles lanes 0,1,2,3 continuously, one lane per cycle. Each lane is serviced only while running. For the lane under service, with head time h and song clock t, widths are extended to 21 bits before comparing:
  - Queue non-empty and t > h+GOOD_WIN: pop, grade MISS, combo=0. pend is kept and is evaluated against the new head on a later visit.
  - Else if pend is set and the queue is empty, or h > t+GOOD_WIN (too early): clear pend, no judgement.
  - Else if pend is set: pop, clear pend, d=|t−h|. d≤PERFECT_WIN gives PERFECT (+300). Else d≤GREAT_WIN gives GREAT (+100). Else GOOD (+50). combo +1.
- Arithmetic: score saturates at 0xFFFFFFFF. combo saturates at 0xFFFF. max_combo = max(max_combo, new combo).
- Not running: presses are discarded, not latched. The queues still accept pushes so a chart can be preloaded before `start`.

## Timing
- Press edge on keys at cycle n, then pend set at n+1, then serviced within 4 cycles.
- judge_valid, grade, lane, score, combo and max_combo are all registered and update together, 1 cycle after service.
- Worst-case press-to-judgement latency: 6 cycles.
- note_ready is combinational from note_lane and the queue count. Push latency: the note becomes head-visible the next cycle.
- A MISS is flagged at the first scan visit where t > h+GOOD_WIN, which is at most 4 cycles after the tick that crosses the threshold.
- Reset mid-song returns the block to idle immediately.

## Test plan
- Push lane0 note at 1000, start, press a at song_ms=1030: GREAT is not expected; required response is PERFECT (d=30), score=300, combo=1.
- Push lane2 notes at 500 and 600, press k at 590 and 700: the first press judges note 500 with d=90, giving GOOD (+50), and note 600 stays queued. The second press gives GREAT (+100, d=100 ≤ 80? no, so GOOD +50). Check score=100, combo=2.
- Lane1 note at 200, no press: MISS pulse with judge_lane=1 after song_ms reaches 321, combo reset from 5 to 0, and max_combo holds 5.
- Press l at 100 with lane3 head at 400: no judge_valid, the note is retained, and a later press at 400 gives PERFECT.
- Push 5 notes to lane0 before start: note_ready drops after 4 pushes, the 5th is dropped, and overflow=1. Then `start` clears overflow and the queue.
- Presses on all 4 lanes in the same cycle, all on time: 4 judge_valid pulses on consecutive cycles in lane order from the scan position, with combo=4. Assert rst mid-sequence: all outputs return to 0 asynchronously.
